writeback_stage: RTL and testbench



---
 rtl/writeback_stage_if.sv | 26 ++
 rtl/writeback_stage.sv | 104 ++++++++++
 tb/tb_writeback_stage.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_stage_if.sv
// Memory-stage handshake plus register-file write port and forwarding bus of writeback_stage.
interface writeback_stage_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_opcode;
    logic [2:0] in_rd;
    logic [7:0] in_alu;
    logic [7:0] in_mem;
    logic [7:0] in_imm;
    logic       RegWrite;
    logic [2:0] write_reg;
    logic [7:0] write_data;
    logic       fwd_valid;
    logic [2:0] fwd_reg;
    logic [7:0] fwd_data;

    modport master (
        output in_valid, in_opcode, in_rd, in_alu, in_mem, in_imm,
        input  in_ready, RegWrite, write_reg, write_data, fwd_valid, fwd_reg, fwd_data
    );

    modport slave (
        input  in_valid, in_opcode, in_rd, in_alu, in_mem, in_imm,
        output in_ready, RegWrite, write_reg, write_data, fwd_valid, fwd_reg, fwd_data
    );
endinterface

// File: rtl/writeback_stage.sv
// Final pipeline stage: 2-entry retire FIFO feeding the register-file write port and forwarding.
// Optional retire counter enabled by defining WB_RETIRE_COUNT_EN.
module writeback_stage #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    writeback_stage_if.slave bus,
    input  logic             wb_hold,
    input  logic             flush,
    output logic [CNT_W-1:0] retire_count
);
    typedef struct packed {
        logic       wr;
        logic [2:0] rd;
        logic [7:0] data;
    } entry_t;

    entry_t     fifo_q [2];
    entry_t     enq_entry;
    entry_t     head;
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       not_empty, push, pop;

    // Only the resolved result is stored; non-writing opcodes keep data at zero.
    always_comb begin
        enq_entry    = '0;
        enq_entry.rd = bus.in_rd;
        if (bus.in_opcode[3] == 1'b0) begin
            enq_entry.wr   = 1'b1;
            enq_entry.data = bus.in_alu;
        end else if (bus.in_opcode == 4'b1001) begin
            enq_entry.wr   = 1'b1;
            enq_entry.data = bus.in_mem;
        end else if (bus.in_opcode == 4'b1010) begin
            enq_entry.wr   = 1'b1;
            enq_entry.data = bus.in_imm;
        end
    end

    assign not_empty    = (count_q != 2'd0);
    assign bus.in_ready = (count_q < 2'(DEPTH));
    assign push         = bus.in_valid & bus.in_ready & ~flush;
    assign pop          = not_empty & ~wb_hold;
    assign head         = not_empty ? fifo_q[rd_ptr_q] : '0;

    assign bus.RegWrite   = pop & head.wr;
    assign bus.write_reg  = head.rd;
    assign bus.write_data = head.data;
    assign bus.fwd_valid  = head.wr;
    assign bus.fwd_reg    = head.rd;
    assign bus.fwd_data   = head.data;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) wr_ptr_d = ~wr_ptr_q;
            if (pop)  rd_ptr_d = ~rd_ptr_q;
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: empty entries are masked by count_q.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= enq_entry;
    end

`ifdef WB_RETIRE_COUNT_EN
    logic [CNT_W-1:0] retire_cnt_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            retire_cnt_q <= '0;
        end else if (pop) begin
            retire_cnt_q <= retire_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign retire_count = retire_cnt_q;
`else
    assign retire_count = '0;
`endif
endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios plus randomized traffic vs a queue model.
module tb_writeback_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wb_hold = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] retire_count;
    logic [3:0]  retire_count4;
    int          checks = 0;
    int          errors = 0;

`ifdef WB_RETIRE_COUNT_EN
    localparam bit RcEn = 1'b1;
`else
    localparam bit RcEn = 1'b0;
`endif

    writeback_stage_if bus ();
    writeback_stage_if bus4 ();

    assign bus4.in_valid  = bus.in_valid;
    assign bus4.in_opcode = bus.in_opcode;
    assign bus4.in_rd     = bus.in_rd;
    assign bus4.in_alu    = bus.in_alu;
    assign bus4.in_mem    = bus.in_mem;
    assign bus4.in_imm    = bus.in_imm;

    writeback_stage #(.DEPTH(2), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .bus(bus), .wb_hold(wb_hold), .flush(flush),
        .retire_count(retire_count)
    );

    writeback_stage #(.DEPTH(2), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .bus(bus4), .wb_hold(wb_hold), .flush(flush),
        .retire_count(retire_count4)
    );

    always #5 clk = ~clk;

    // Reference model: an ordered queue of resolved entries and a retire tally.
    typedef struct {
        bit       wr;
        bit [2:0] rd;
        bit [7:0] data;
    } ent_t;

    ent_t        q[$];
    int unsigned model_rc = 0;

    function automatic ent_t resolve(bit [3:0] op, bit [2:0] rd, bit [7:0] alu, bit [7:0] mem,
                                     bit [7:0] imm);
        ent_t e;
        e.rd = rd; e.wr = 1'b0; e.data = 8'd0;
        if (op <= 4'd7)       begin e.wr = 1'b1; e.data = alu; end
        else if (op == 4'd9)  begin e.wr = 1'b1; e.data = mem; end
        else if (op == 4'd10) begin e.wr = 1'b1; e.data = imm; end
        return e;
    endfunction

    function automatic bit e_ready();      return q.size() < 2; endfunction
    function automatic bit e_fvalid();     return q.size() > 0 && q[0].wr; endfunction
    function automatic bit e_regwrite();   return e_fvalid() && !wb_hold; endfunction
    function automatic bit [2:0] e_reg();  return q.size() > 0 ? q[0].rd : 3'd0; endfunction
    function automatic bit [7:0] e_data(); return q.size() > 0 ? q[0].data : 8'd0; endfunction
    function automatic bit [15:0] e_rc(int w);
        int unsigned mask = (32'd1 << w) - 32'd1;
        return RcEn ? 16'(model_rc & mask) : 16'd0;
    endfunction

    task automatic drive(bit v, bit [3:0] op, bit [2:0] rd, bit [7:0] alu, bit [7:0] mem,
                         bit [7:0] imm, bit hold, bit fl);
        bus.in_valid = v; bus.in_opcode = op; bus.in_rd = rd;
        bus.in_alu = alu; bus.in_mem = mem; bus.in_imm = imm;
        wb_hold = hold; flush = fl;
        @(negedge clk);
    endtask

    task automatic idle(bit hold);
        drive(1'b0, 4'd0, 3'd0, 8'd0, 8'd0, 8'd0, hold, 1'b0);
    endtask

    // Advance the model by one clock using the currently driven inputs, then cross the edge.
    task automatic tick();
        bit   do_pop, do_push;
        ent_t e;
        if (!reset) begin
            q.delete();
            model_rc = 0;
        end else begin
            do_pop  = q.size() > 0 && !wb_hold;
            do_push = bus.in_valid && e_ready() && !flush;
            e = resolve(bus.in_opcode, bus.in_rd, bus.in_alu, bus.in_mem, bus.in_imm);
            if (do_pop) begin q.delete(0); model_rc++; end
            if (flush) q.delete();
            if (do_push) q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; idle(1'b0); tick(); tick();
        reset = 1'b1; idle(1'b0);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", bus.in_ready); end
        checks++; if ({bus.RegWrite, bus.fwd_valid} !== 2'b00) begin errors++; $display("FAIL reset_valids got %b want 00", {bus.RegWrite, bus.fwd_valid}); end
        checks++; if ({bus.write_reg, bus.write_data, bus.fwd_reg, bus.fwd_data} !== 22'd0) begin errors++; $display("FAIL reset_data got %h want 0", {bus.write_reg, bus.write_data, bus.fwd_reg, bus.fwd_data}); end
        checks++; if (retire_count !== 16'd0) begin errors++; $display("FAIL reset_retire_count got %0d want 0", retire_count); end
    endtask

    task automatic test_basic();
        drive(1'b1, 4'b0000, 3'd5, 8'hFD, 8'h11, 8'h22, 1'b0, 1'b0); tick();
        idle(1'b0);
        checks++; if ({bus.RegWrite, bus.write_reg, bus.write_data, bus.fwd_valid} !== {1'b1, 3'd5, 8'hFD, 1'b1}) begin errors++; $display("FAIL basic_alu got %b/%0d/%h/%b want 1/5/fd/1", bus.RegWrite, bus.write_reg, bus.write_data, bus.fwd_valid); end
        tick();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 4'b1001, 3'd2, 8'h01, 8'h7F, 8'h02, 1'b0, 1'b0);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready0 got %0b want 1", bus.in_ready); end
        tick();
        drive(1'b1, 4'b1010, 3'd3, 8'h03, 8'h04, 8'h80, 1'b0, 1'b0);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready1 got %0b want 1", bus.in_ready); end
        checks++; if ({bus.RegWrite, bus.write_reg, bus.write_data} !== {1'b1, 3'd2, 8'h7F}) begin errors++; $display("FAIL b2b_load got %b/%0d/%h want 1/2/7f", bus.RegWrite, bus.write_reg, bus.write_data); end
        tick(); idle(1'b0);
        checks++; if ({bus.RegWrite, bus.write_reg, bus.write_data} !== {1'b1, 3'd3, 8'h80}) begin errors++; $display("FAIL b2b_li got %b/%0d/%h want 1/3/80", bus.RegWrite, bus.write_reg, bus.write_data); end
        tick();
    endtask

    task automatic test_hold();
        drive(1'b1, 4'b0000, 3'd1, 8'h11, 8'hAA, 8'hBB, 1'b1, 1'b0); tick();
        drive(1'b1, 4'b1001, 3'd2, 8'hCC, 8'h22, 8'hDD, 1'b1, 1'b0);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL hold_ready1 got %0b want 1", bus.in_ready); end
        tick();
        drive(1'b1, 4'b1010, 3'd3, 8'hEE, 8'hEE, 8'h33, 1'b1, 1'b0);
        checks++; if ({bus.in_ready, bus.RegWrite, bus.fwd_valid, bus.fwd_data} !== {1'b0, 1'b0, 1'b1, 8'h11}) begin errors++; $display("FAIL hold_full got rdy=%b we=%b fv=%b fd=%h want 0/0/1/11", bus.in_ready, bus.RegWrite, bus.fwd_valid, bus.fwd_data); end
        tick(); idle(1'b0);
        checks++; if ({bus.RegWrite, bus.write_reg, bus.write_data} !== {1'b1, 3'd1, 8'h11}) begin errors++; $display("FAIL hold_rel0 got %b/%0d/%h want 1/1/11", bus.RegWrite, bus.write_reg, bus.write_data); end
        tick(); idle(1'b0);
        checks++; if ({bus.RegWrite, bus.write_reg, bus.write_data} !== {1'b1, 3'd2, 8'h22}) begin errors++; $display("FAIL hold_rel1 got %b/%0d/%h want 1/2/22", bus.RegWrite, bus.write_reg, bus.write_data); end
        tick(); idle(1'b0);
        checks++; if ({bus.RegWrite, bus.fwd_valid, bus.in_ready} !== 3'b001) begin errors++; $display("FAIL hold_drained got %b want 001", {bus.RegWrite, bus.fwd_valid, bus.in_ready}); end
    endtask

    task automatic test_store_branch();
        drive(1'b1, 4'b1000, 3'd1, 8'h55, 8'h55, 8'h55, 1'b0, 1'b0); tick();
        drive(1'b1, 4'b1011, 3'd2, 8'h66, 8'h66, 8'h66, 1'b0, 1'b0);
        checks++; if ({bus.RegWrite, bus.fwd_valid} !== 2'b00) begin errors++; $display("FAIL store_nowrite got %b want 00", {bus.RegWrite, bus.fwd_valid}); end
        tick(); idle(1'b0);
        checks++; if ({bus.RegWrite, bus.fwd_valid} !== 2'b00) begin errors++; $display("FAIL branch_nowrite got %b want 00", {bus.RegWrite, bus.fwd_valid}); end
        tick(); idle(1'b0);
        checks++; if (retire_count !== e_rc(16)) begin errors++; $display("FAIL store_branch_count got %0d want %0d", retire_count, e_rc(16)); end
    endtask

    task automatic test_flush();
        drive(1'b1, 4'b0000, 3'd4, 8'h01, 8'h00, 8'h00, 1'b1, 1'b0); tick();
        drive(1'b1, 4'b0000, 3'd5, 8'h02, 8'h00, 8'h00, 1'b1, 1'b0); tick();
        drive(1'b1, 4'b0000, 3'd6, 8'h03, 8'h00, 8'h00, 1'b1, 1'b1);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_full_ready got %0b want 0", bus.in_ready); end
        tick(); idle(1'b0);
        checks++; if ({bus.in_ready, bus.fwd_valid, bus.RegWrite} !== 3'b100) begin errors++; $display("FAIL flush_empty got %b want 100", {bus.in_ready, bus.fwd_valid, bus.RegWrite}); end
        tick(); idle(1'b0);
        checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL flush_dropped got %0b want 0", bus.RegWrite); end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 4'b0001, 3'd1, 8'h41, 8'h00, 8'h00, 1'b1, 1'b0); tick();
        drive(1'b1, 4'b1001, 3'd2, 8'h00, 8'h42, 8'h00, 1'b1, 1'b0); tick();
        reset = 1'b0;
        drive(1'b1, 4'b1010, 3'd3, 8'h00, 8'h00, 8'h43, 1'b0, 1'b0); tick();
        reset = 1'b1; idle(1'b0);
        checks++; if ({bus.in_ready, bus.RegWrite, bus.fwd_valid} !== 3'b100) begin errors++; $display("FAIL rstmid_ctrl got %b want 100", {bus.in_ready, bus.RegWrite, bus.fwd_valid}); end
        checks++; if ({bus.write_reg, bus.write_data, bus.fwd_reg, bus.fwd_data} !== 22'd0) begin errors++; $display("FAIL rstmid_data got %h want 0", {bus.write_reg, bus.write_data, bus.fwd_reg, bus.fwd_data}); end
        checks++; if ({retire_count, retire_count4} !== 20'd0) begin errors++; $display("FAIL rstmid_count got %h want 0", {retire_count, retire_count4}); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 4'b1000, 3'(i), 8'(i), 8'h00, 8'h00, 1'b0, 1'b0); tick();
        end
        idle(1'b0); tick(); idle(1'b0);
        checks++; if (retire_count4 !== 4'(e_rc(4))) begin errors++; $display("FAIL wrap_cnt4 got %0d want %0d", retire_count4, e_rc(4)); end
        checks++; if (retire_count !== e_rc(16)) begin errors++; $display("FAIL wrap_cnt16 got %0d want %0d", retire_count, e_rc(16)); end
    endtask

    task automatic test_random();
        logic [44:0] got, exp;
        logic [15:0] rc4;
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(63) != 0);
            drive(1'($urandom_range(3) != 0), 4'($urandom), 3'($urandom), 8'($urandom),
                  8'($urandom), 8'($urandom), 1'($urandom_range(2) == 0),
                  1'($urandom_range(15) == 0));
            rc4 = e_rc(4);
            exp = {e_ready(), e_regwrite(), e_reg(), e_data(), e_fvalid(), e_reg(), e_data(),
                   e_rc(16), rc4[3:0]};
            got = {bus.in_ready, bus.RegWrite, bus.write_reg, bus.write_data, bus.fwd_valid,
                   bus.fwd_reg, bus.fwd_data, retire_count, retire_count4};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random_cycle%0d got %h want %h", i, got, exp);
            end
            tick();
        end
        reset = 1'b1;
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_opcode = '0; bus.in_rd = '0;
        bus.in_alu = '0; bus.in_mem = '0; bus.in_imm = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_hold();
        test_store_branch();
        test_flush();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
